uart_frame_parser: RTL
======================

Name: uart_frame_parser

Overview:
- Consumes the byte stream produced by the UART receiver (one-cycle `data_ready` pulse plus 8-bit data) and extracts framed commands for the raytracer core.
- Frame format: `SYNC_BYTE`, CMD, LEN, LEN payload bytes, CHK. CHK is the XOR of CMD, LEN and all payload bytes.
- Payload is packed into 32-bit little-endian words and buffered in an internal FIFO, drained through a valid/ready interface.
- Frame completion or failure is reported by one-cycle status pulses.

Parameters:
- SYNC_BYTE, 8'hA5, start-of-frame marker.
- MAX_LEN, 64, maximum payload bytes per frame; must be a multiple of 4.
- TIMEOUT, 3000000, idle clock cycles allowed between bytes inside a frame (20 ms at 150 MHz).
- FIFO_DEPTH, 8, payload word FIFO depth; power of two.

Ports:
- clk  in  1  system clock, 150 MHz.
- rst  in  1  synchronous, active-low reset (0 = reset).
- byte_valid  in  1  one-cycle strobe, byte available (receiver `data_ready`).
- byte_data  in  8  received byte, valid when byte_valid=1.
- word_valid  out  1  FIFO head word available.
- word_data  out  32  FIFO head word; first payload byte in [7:0].
- word_last  out  1  head word is the final payload word of its frame.
- word_ready  in  1  consumer accepts head word when word_valid=1.
- cmd  out  8  CMD byte of the most recent frame; held until the next CMD byte.
- frame_start  out  1  pulse when CMD byte is accepted.
- frame_ok  out  1  pulse when CHK matches.
- frame_err  out  1  pulse on any frame error.
- err_code  out  2  valid with frame_err: 0 checksum, 1 bad length, 2 timeout, 3 overflow.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, FIFO emptied, timeout counter cleared.
  - All outputs 0, including cmd and word_data.
  - Applies mid-frame; the partial frame is discarded with no error pulse.
- States: IDLE, CMD, LEN, PAYLOAD, CHK. All transitions occur at the edge sampling byte_valid=1.
  - IDLE: byte==SYNC_BYTE -> CMD; other bytes ignored silently.
  - CMD: latch cmd, clear running XOR to byte, pulse frame_start next cycle -> LEN. A SYNC_BYTE value here is treated as CMD, not a resync.
  - LEN: XOR in the byte, load remaining-count.
    - LEN==0 -> CHK.
    - LEN>MAX_LEN or LEN[1:0]!=0 -> frame_err, err_code=1, IDLE.
    - Otherwise -> PAYLOAD.
  - PAYLOAD: XOR in each byte and shift it into the word assembler (byte k of a word goes to bits [8k+7:8k]).
    - On every 4th byte, the word is pushed to the FIFO at the same edge, with word_last=1 if it is the frame's final word.
    - After the last byte -> CHK.
  - CHK: byte==running XOR -> frame_ok, else frame_err with err_code=0. Then -> IDLE.
- Status outputs:
  - frame_start, frame_ok and frame_err are registered pulses, exactly one cycle wide, asserted the cycle after the causing edge.
  - frame_ok and frame_err are never asserted together.
- Word latency: a word pushed at edge n has word_valid=1 from edge n onward if the FIFO was empty (show-ahead head register).
- FIFO:
  - Pop occurs when word_valid && word_ready.
  - Push and pop in the same cycle are both performed, including when the FIFO is full; this is not an overflow.
- Overflow: a push while full with no simultaneous pop drops the word, pulses frame_err with err_code=3, and goes to IDLE.
- Error handling and the FIFO:
  - Words already queued are never flushed on error.
  - The consumer commits a frame's words only after frame_ok and discards on frame_err.
- Timeout:
  - The counter clears on every byte_valid and in IDLE, and increments each cycle in any other state.
  - Reaching TIMEOUT-1 gives frame_err with err_code=2 next cycle, and the state goes to IDLE.
  - If byte_valid arrives in the same cycle, the byte wins and the counter clears.
- busy reflects the registered state.
- byte_valid asserted on consecutive cycles is legal; every strobe is processed.

Test Plan:
- Good frame: A5 01 04 11 22 33 44 41 -> frame_start once, cmd=0x01, one word 0x44332211 with word_last=1, frame_ok pulse after the 0x41 edge, err_code unused, busy=0 afterwards.
- Bad checksum: same frame ending in 0x40 -> word 0x44332211 is still emitted; frame_err=1 with err_code=0; frame_ok never asserts.
- Bad length: A5 02 03 -> frame_err with err_code=1 the cycle after the 0x03 edge. A following A5 07 00 07 -> frame_ok, cmd=0x07, no words.
- Timeout: A5 02 then no bytes -> frame_err with err_code=2 exactly TIMEOUT cycles after the 0x02 edge; busy falls the same cycle.
- Overflow: word_ready=0, A5 05 24 + 36 payload bytes -> 8 words queued, frame_err with err_code=3 on the 9th word. Then word_ready=1 -> the 8 words drain in order.
- Reset mid-payload: rst=0 for 1 cycle after 2 payload bytes -> all outputs 0, FIFO empty, busy=0. Next good frame passes as in the good-frame test.

Source files
------------

// File: rtl/uart_frame_parser.sv
// uart_frame_parser
// ------------------------------------------------------------------
// Purpose:
//   Extracts framed commands from the UART receiver byte stream.
//   A frame is SYNC_BYTE, CMD, LEN, LEN payload bytes, CHK. CHK is the
//   XOR of CMD, LEN and every payload byte. The payload is packed into
//   32-bit little-endian words and held in a show-ahead FIFO. The
//   consumer drains the FIFO through a valid/ready handshake. Frame
//   start, success and failure are reported as one-cycle pulses.
//
// Ports:
//   i_clk          system clock
//   i_rst          synchronous reset, active low (0 = reset)
//   i_byte_valid   one-cycle strobe marking a received byte
//   i_byte_data    received byte, valid with i_byte_valid
//   o_word_valid   FIFO head word available
//   o_word_data    FIFO head word; the first payload byte is in [7:0]
//   o_word_last    head word is the final payload word of its frame
//   i_word_ready   consumer takes the head word when o_word_valid=1
//   o_cmd          CMD byte of the most recent frame
//   o_frame_start  pulse after a CMD byte is accepted
//   o_frame_ok     pulse after a matching CHK byte
//   o_frame_err    pulse after any frame error
//   o_err_code     0 checksum, 1 bad length, 2 timeout, 3 overflow
//   o_busy         parser is inside a frame (state != IDLE)
// ------------------------------------------------------------------
module uart_frame_parser #(
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         MAX_LEN    = 64,
  parameter int         TIMEOUT    = 3000000,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte_data,
  output logic        o_word_valid,
  output logic [31:0] o_word_data,
  output logic        o_word_last,
  input  logic        i_word_ready,
  output logic [7:0]  o_cmd,
  output logic        o_frame_start,
  output logic        o_frame_ok,
  output logic        o_frame_err,
  output logic [1:0]  o_err_code,
  output logic        o_busy
);

  localparam int             TW        = $clog2(TIMEOUT);
  localparam int             PW        = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0]  TMAX      = TW'(TIMEOUT - 1);
  localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [PW:0]    FULL_CNT  = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_PAYLOAD,
    S_CHK
  } state_t;

  state_t          r_state;
  state_t          w_nstate;
  logic [7:0]      r_cmd;
  logic [7:0]      r_xor;
  logic [7:0]      r_remain;
  logic [1:0]      r_idx;
  logic [23:0]     r_word;
  logic [TW-1:0]   r_tcnt;
  logic            r_frame_start;
  logic            r_frame_ok;
  logic            r_frame_err;
  logic [1:0]      r_err_code;

  logic [32:0]     r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [PW:0]     r_count;

  logic            w_start_nxt;
  logic            w_ok_nxt;
  logic            w_err_nxt;
  logic [1:0]      w_code_nxt;
  logic            w_timeout;
  logic            w_word_done;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_overflow;
  logic            w_last;
  logic [32:0]     w_head;

  // FIFO handshake. A completed word that meets a full FIFO is only an
  // overflow when the consumer is not freeing a slot at the same edge.
  assign w_full      = (r_count == FULL_CNT);
  assign w_pop       = o_word_valid && i_word_ready;
  assign w_word_done = (r_state == S_PAYLOAD) && i_byte_valid && (r_idx == 2'd3);
  assign w_overflow  = w_word_done && w_full && !w_pop;
  assign w_push      = w_word_done && !w_overflow;
  assign w_last      = (r_remain == 8'd1);
  assign w_timeout   = (r_state != S_IDLE) && (r_tcnt == TMAX);
  assign w_head      = r_mem[r_rptr];

  assign o_word_valid  = (r_count != '0);
  assign o_word_data   = o_word_valid ? w_head[31:0] : 32'd0;
  assign o_word_last   = o_word_valid && w_head[32];
  assign o_cmd         = r_cmd;
  assign o_frame_start = r_frame_start;
  assign o_frame_ok    = r_frame_ok;
  assign o_frame_err   = r_frame_err;
  assign o_err_code    = r_err_code;
  assign o_busy        = (r_state != S_IDLE);

  // Next-state and status-pulse decode. A byte strobe always takes
  // priority over the timeout, so a byte arriving on the last allowed
  // cycle keeps the frame alive.
  always_comb begin
    w_nstate    = r_state;
    w_start_nxt = 1'b0;
    w_ok_nxt    = 1'b0;
    w_err_nxt   = 1'b0;
    w_code_nxt  = 2'd0;
    if (i_byte_valid) begin
      case (r_state)
        S_IDLE: begin
          if (i_byte_data == SYNC_BYTE) begin
            w_nstate = S_CMD;
          end
        end
        S_CMD: begin
          w_nstate    = S_LEN;
          w_start_nxt = 1'b1;
        end
        S_LEN: begin
          if (i_byte_data == 8'd0) begin
            w_nstate = S_CHK;
          end else if ((i_byte_data > MAX_LEN_B) || (i_byte_data[1:0] != 2'd0)) begin
            w_nstate   = S_IDLE;
            w_err_nxt  = 1'b1;
            w_code_nxt = 2'd1;
          end else begin
            w_nstate = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (w_overflow) begin
            w_nstate   = S_IDLE;
            w_err_nxt  = 1'b1;
            w_code_nxt = 2'd3;
          end else if (w_last) begin
            w_nstate = S_CHK;
          end
        end
        S_CHK: begin
          w_nstate = S_IDLE;
          if (i_byte_data == r_xor) begin
            w_ok_nxt = 1'b1;
          end else begin
            w_err_nxt  = 1'b1;
            w_code_nxt = 2'd0;
          end
        end
        default: begin
          w_nstate = S_IDLE;
        end
      endcase
    end else if (w_timeout) begin
      w_nstate   = S_IDLE;
      w_err_nxt  = 1'b1;
      w_code_nxt = 2'd2;
    end
  end

  // State register, status pulses and the frame datapath. Payload bytes
  // shift in from the top so that after three bytes the first one sits
  // in [7:0]; the fourth byte completes the word on its way into the FIFO.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state       <= S_IDLE;
      r_cmd         <= 8'd0;
      r_xor         <= 8'd0;
      r_remain      <= 8'd0;
      r_idx         <= 2'd0;
      r_word        <= 24'd0;
      r_tcnt        <= '0;
      r_frame_start <= 1'b0;
      r_frame_ok    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_err_code    <= 2'd0;
    end else begin
      r_state       <= w_nstate;
      r_frame_start <= w_start_nxt;
      r_frame_ok    <= w_ok_nxt;
      r_frame_err   <= w_err_nxt;
      r_err_code    <= w_code_nxt;

      if (i_byte_valid || (r_state == S_IDLE) || w_timeout) begin
        r_tcnt <= '0;
      end else begin
        r_tcnt <= r_tcnt + TW'(1);
      end

      if (i_byte_valid) begin
        case (r_state)
          S_CMD: begin
            r_cmd <= i_byte_data;
            r_xor <= i_byte_data;
          end
          S_LEN: begin
            r_xor    <= r_xor ^ i_byte_data;
            r_remain <= i_byte_data;
            r_idx    <= 2'd0;
          end
          S_PAYLOAD: begin
            r_xor    <= r_xor ^ i_byte_data;
            r_remain <= r_remain - 8'd1;
            r_idx    <= r_idx + 2'd1;
            r_word   <= {i_byte_data, r_word[23:8]};
          end
          default: begin
          end
        endcase
      end
    end
  end

  // FIFO pointers and occupancy. Queued words survive frame errors; only
  // reset empties the FIFO.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW + 1)'(1);
        2'b01:   r_count <= r_count - (PW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; the top bit carries the last-word flag. Contents need
  // no reset because the read side is gated by the occupancy count.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {w_last, i_byte_data, r_word};
    end
  end

endmodule
